dram_model: RTL and testbench
=============================

DRAM_MODEL -- requirements
Module: dram_model

Interface
REQ-001 Parameter CL, default 5, meaning: CAS read latency in CK cycles from column-read command to Q/VALID.
REQ-002 Parameter DEPTH, default 2097152, meaning: words per byte lane (21-bit word address).
REQ-003 CK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 CSn  input  1  chip select, active-low; commands ignored when high.
REQ-006 RASn  input  1  row strobe, active-low.
REQ-007 CASn  input  1  column strobe, active-low.
REQ-008 WEn  input  4  per-byte write enable, active-low; WEn[i] controls bits 8i+7:8i.
REQ-009 A  input  11  multiplexed address: row = A[10:0], column = A[9:0].
REQ-010 D  input  32  write data.
REQ-011 Q  output  32  read data, registered.
REQ-012 VALID  output  1  one-cycle pulse qualifying Q.

Function
REQ-013 Storage: four byte arrays Memory_byte0..Memory_byte3, DEPTH x 8 each, byte3 = bits 31:24; preloadable by hierarchical $readmemh; never cleared by RST.
REQ-014 State: row_open flag, 11-bit row register, CL-deep read pipeline (valid bit + 32-bit data per stage).
REQ-015 Activate: CSn=0, RASn=0, row_open=0 -> row <= A, row_open <= 1; RASn=0 while already open is ignored (row unchanged).
REQ-016 Precharge: CSn=0, RASn=1, row_open=1 -> row_open <= 0.
REQ-017 Column access: CSn=0, CASn=0, row_open=1 (pre-edge value) -> word address = {row, A[9:0]}.
REQ-018 Write: column access with WEn != 4'hF -> each lane with WEn[i]=0 stores D lane i that edge; lanes with WEn[i]=1 unchanged; no VALID.
REQ-019 Read: column access with WEn = 4'hF -> word read at command edge enters pipeline; Q and VALID update exactly CL edges later, VALID high one cycle.
REQ-020 Same-edge CASn=0 and RASn=1 on open row: column access uses current row, then row closes.
REQ-021 Column access with row_open=0 or CSn=1 is ignored; no memory change, no VALID.
REQ-022 Back-to-back reads on consecutive cycles allowed; each yields its own VALID pulse, in order, CL cycles after issue.
REQ-023 Read data sampled at issue; a later write to the same word does not alter an in-flight read.
REQ-024 Write followed by read of the same word returns the written bytes.
REQ-025 Q holds last read value when VALID=0; pipeline advances every cycle regardless of CSn.
REQ-026 Addresses wrap modulo DEPTH; no out-of-range access.

Reset
REQ-027 RST=1 at a rising edge: Q <= 0, VALID <= 0, row_open <= 0, row <= 0, all pipeline valid bits cleared; commands that cycle ignored.
REQ-028 Reset mid-read: in-flight reads are discarded, no VALID after release.
REQ-029 Memory contents retained across reset.

Verification
REQ-030 Preload word 0x000401 = 0xDEADBEEF; activate row 0x001, CAS read column 0x001 -> Q = 0xDEADBEEF, VALID high exactly 5 cycles after CAS edge, one cycle.
REQ-031 Open row 0x7FF, write column 0x3FF with D = 0x12345678, WEn = 4'b1010 over preload 0xAABBCCDD -> subsequent read returns 0xAA34CC78.
REQ-032 Four consecutive CAS reads of columns 0..3 holding 0x10..0x13 -> four consecutive VALID cycles, Q = 0x10,0x11,0x12,0x13.
REQ-033 CAS read with no open row, or with CSn=1 -> no VALID within 10 cycles, memory unchanged.
REQ-034 Issue read, assert RST 2 cycles later for 1 cycle -> Q = 0, no VALID pulse; preloaded data still readable after re-activation.
REQ-035 Read then write of same word on next cycle -> VALID returns old value; re-read returns new value.

Source files
------------

// File: rtl/dram_model.sv
// Behavioural-synthesizable single-bank DRAM with a fixed CAS read latency.
// Ports:
//   CK     - sole clock; all state changes on the rising edge
//   RST    - synchronous active-high reset (memory contents are retained)
//   CSn    - chip select, active-low; commands ignored when high
//   RASn   - row strobe, active-low (activate when closed, precharge when high on open row)
//   CASn   - column strobe, active-low
//   WEn    - per-byte write enable, active-low; WEn[i] covers bits 8i+7:8i
//   A      - multiplexed address: row = A[10:0], column = A[9:0]
//   D      - write data
//   Q      - registered read data, holds the last read when VALID is low
//   VALID  - one-cycle pulse qualifying Q, CL edges after a column read
module dram_model #(
    parameter int unsigned CL    = 5,
    parameter int unsigned DEPTH = 2097152
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        CSn,
    input  logic        RASn,
    input  logic        CASn,
    input  logic [3:0]  WEn,
    input  logic [10:0] A,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic        VALID
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WAW = 21;

    // Byte-lane storage; names kept stable for hierarchical preload.
    logic [7:0]  Memory_byte0 [DEPTH];
    logic [7:0]  Memory_byte1 [DEPTH];
    logic [7:0]  Memory_byte2 [DEPTH];
    logic [7:0]  Memory_byte3 [DEPTH];

    logic        row_open;
    logic [10:0] row;
    logic [CL-1:0] pipe_vld;
    logic [31:0]   pipe_data [CL];

    logic           cmd_en_c;
    logic           activate_c;
    logic           precharge_c;
    logic           column_c;
    logic           write_c;
    logic           read_c;
    logic [WAW-1:0] word_addr_c;
    logic [AW-1:0]  idx_c;
    logic [31:0]    rd_word_c;

    // Command decode against the pre-edge row state; reset suppresses all commands.
    always_comb begin
        cmd_en_c    = !RST && !CSn;
        activate_c  = cmd_en_c && !RASn && !row_open;
        precharge_c = cmd_en_c && RASn && row_open;
        column_c    = cmd_en_c && !CASn && row_open;
        write_c     = column_c && (WEn != 4'hF);
        read_c      = column_c && (WEn == 4'hF);
        word_addr_c = {row, A[9:0]};
        idx_c       = AW'(32'(word_addr_c) % 32'(DEPTH));
        rd_word_c   = {Memory_byte3[idx_c], Memory_byte2[idx_c],
                       Memory_byte1[idx_c], Memory_byte0[idx_c]};
    end

    // Per-lane writes; storage has no reset.
    always_ff @(posedge CK) begin
        if (write_c) begin
            if (!WEn[0]) Memory_byte0[idx_c] <= D[7:0];
            if (!WEn[1]) Memory_byte1[idx_c] <= D[15:8];
            if (!WEn[2]) Memory_byte2[idx_c] <= D[23:16];
            if (!WEn[3]) Memory_byte3[idx_c] <= D[31:24];
        end
    end

    // Read data pipeline: word captured at the command edge, shifted every cycle.
    always_ff @(posedge CK) begin
        pipe_data[0] <= rd_word_c;
        for (int unsigned i = 1; i < CL; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    // Row state, pipeline valid bits and output registers.
    always_ff @(posedge CK) begin
        if (RST) begin
            row_open <= 1'b0;
            row      <= '0;
            pipe_vld <= '0;
            Q        <= '0;
            VALID    <= 1'b0;
        end else begin
            if (activate_c) begin
                row      <= A;
                row_open <= 1'b1;
            end else if (precharge_c) begin
                row_open <= 1'b0;
            end
            pipe_vld[0] <= read_c;
            for (int unsigned i = 1; i < CL; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
            VALID <= pipe_vld[CL-1];
            if (pipe_vld[CL-1]) begin
                Q <= pipe_data[CL-1];
            end
        end
    end

endmodule

// File: tb/tb_dram_model.sv
// Self-checking bench for dram_model: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a
// transaction-level model (associative memory + queue of pending reads).
module tb_dram_model;

    localparam int unsigned CL    = 5;
    localparam int unsigned DEPTH = 2097152;

    logic        CK;
    logic        RST;
    logic        CSn;
    logic        RASn;
    logic        CASn;
    logic [3:0]  WEn;
    logic [10:0] A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        VALID;

    dram_model #(.CL(CL), .DEPTH(DEPTH)) dut (
        .CK(CK), .RST(RST), .CSn(CSn), .RASn(RASn), .CASn(CASn),
        .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] mem [int unsigned];
    rd_t         pend [$];
    int unsigned cyc = 0;
    bit          m_open = 0;
    logic [10:0] m_row = '0;
    bit          exp_valid = 0;
    logic [31:0] exp_q = '0;
    bit          chk_en = 0;
    bit          was_open;
    int unsigned addr;
    logic [31:0] word;

    function automatic logic [31:0] mem_rd(input int unsigned a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge CK) begin
        cyc++;
        exp_valid = 0;
        if (RST) begin
            m_open = 0;
            m_row  = '0;
            pend.delete();
            exp_q  = '0;
            chk_en = 1;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_valid = 1;
                exp_q     = pend[0].data;
                void'(pend.pop_front());
            end
            if (!CSn) begin
                was_open = m_open;
                if (!CASn && was_open) begin
                    addr = 32'({m_row, A[9:0]}) % DEPTH;
                    word = mem_rd(addr);
                    if (WEn == 4'hF) begin
                        pend.push_back('{due: cyc + CL, data: word});
                    end else begin
                        for (int i = 0; i < 4; i++)
                            if (!WEn[i]) word[8*i +: 8] = D[8*i +: 8];
                        mem[addr] = word;
                    end
                end
                if (!RASn && !was_open) begin
                    m_row  = A;
                    m_open = 1;
                end else if (RASn && was_open) begin
                    m_open = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model once reset has been seen.
    always @(negedge CK) begin
        if (chk_en) begin
            check("model_valid", 32'(VALID), 32'(exp_valid));
            check("model_q", Q, exp_q);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic cs, input logic ras, input logic cas,
                         input logic [3:0] we, input logic [10:0] a, input logic [31:0] d);
        CSn = cs; RASn = ras; CASn = cas; WEn = we; A = a; D = d;
        @(negedge CK);
    endtask

    task automatic idle();                       drive(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0); endtask
    task automatic act(input logic [10:0] r);    drive(1'b0, 1'b0, 1'b1, 4'hF, r, 32'h0);     endtask
    task automatic pre();                        drive(1'b0, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0); endtask
    task automatic wr(input logic [10:0] c, input logic [3:0] we, input logic [31:0] d);
        drive(1'b0, 1'b0, 1'b0, we, c, d);
    endtask
    task automatic rd(input logic [10:0] c);     drive(1'b0, 1'b0, 1'b0, 4'hF, c, 32'h0);     endtask

    // Called right after the read edge: VALID must appear exactly CL edges later, for one cycle.
    task automatic expect_read(input string name, input logic [31:0] lit);
        repeat (CL - 1) idle();
        check({name, "_early"}, 32'(VALID), 32'd0);
        idle();
        check({name, "_valid"}, 32'(VALID), 32'd1);
        check({name, "_q"}, Q, lit);
        idle();
        check({name, "_pulse"}, 32'(VALID), 32'd0);
        check({name, "_hold"}, Q, lit);
    endtask

    logic [10:0] rows [4] = '{11'h000, 11'h001, 11'h002, 11'h7FF};
    logic [9:0]  cols [5] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h3FF};

    initial begin
        RST = 1'b1; CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;
        idle();
        idle();
        check("reset_q", Q, 32'h0);
        check("reset_valid", 32'(VALID), 32'd0);
        RST = 1'b0;

        // Basic read of a word placed at 0x000401.
        act(11'h001);
        wr(11'h001, 4'h0, 32'hDEADBEEF);
        rd(11'h001);
        expect_read("basic_read", 32'hDEADBEEF);
        pre();

        // Partial write over a full word at the top row/column.
        act(11'h7FF);
        wr(11'h3FF, 4'h0, 32'hAABBCCDD);
        wr(11'h3FF, 4'b1010, 32'h12345678);
        rd(11'h3FF);
        expect_read("byte_mask", 32'hAA34CC78);
        pre();

        // Four back-to-back reads.
        act(11'h001);
        for (int i = 0; i < 4; i++) wr(11'(i), 4'h0, 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) rd(11'(i));
        repeat (CL - 4) idle();
        for (int i = 0; i < 4; i++) begin
            idle();
            check("b2b_valid", 32'(VALID), 32'd1);
            check("b2b_q", Q, 32'h10 + 32'(i));
        end
        idle();
        check("b2b_end", 32'(VALID), 32'd0);

        // Ignored accesses: CSn high on open row, then closed row.
        wr(11'h001, 4'h0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 11'h001, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'hF, 11'h001, 32'h0);
        pre();
        drive(1'b0, 1'b1, 1'b0, 4'h0, 11'h001, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 4'hF, 11'h001, 32'h0);
        for (int i = 0; i < 10; i++) begin
            idle();
            check("ignored_no_valid", 32'(VALID), 32'd0);
        end
        act(11'h001);
        rd(11'h001);
        expect_read("ignored_mem_kept", 32'hDEADBEEF);

        // Read with RASn high on open row: served from current row, then row closes.
        drive(1'b0, 1'b1, 1'b0, 4'hF, 11'h001, 32'h0);
        expect_read("read_precharge", 32'hDEADBEEF);
        drive(1'b0, 1'b1, 1'b0, 4'hF, 11'h001, 32'h0);
        for (int i = 0; i < CL + 2; i++) begin
            idle();
            check("closed_after_rp", 32'(VALID), 32'd0);
        end

        // Reset two cycles after a read discards it.
        act(11'h001);
        rd(11'h001);
        idle();
        RST = 1'b1;
        idle();
        RST = 1'b0;
        check("midreset_q", Q, 32'h0);
        check("midreset_valid", 32'(VALID), 32'd0);
        for (int i = 0; i < 10; i++) begin
            idle();
            check("midreset_no_valid", 32'(VALID), 32'd0);
        end
        act(11'h001);
        rd(11'h001);
        expect_read("after_reset", 32'hDEADBEEF);

        // Read then write of the same word on the next cycle.
        rd(11'h001);
        wr(11'h001, 4'h0, 32'hCAFEF00D);
        repeat (CL - 2) idle();
        check("rw_early", 32'(VALID), 32'd0);
        idle();
        check("rw_valid", 32'(VALID), 32'd1);
        check("rw_old", Q, 32'hDEADBEEF);
        rd(11'h001);
        expect_read("rw_new", 32'hCAFEF00D);
        pre();

        // Randomized phase over a fully initialised address pool.
        foreach (rows[r]) begin
            act(rows[r]);
            foreach (cols[c]) wr({1'b0, cols[c]}, 4'h0, $urandom);
            pre();
        end
        for (int n = 0; n < 800; n++) begin
            logic [10:0] a;
            logic [3:0]  we;
            RST = ($urandom_range(0, 79) == 0);
            if (m_open) a = {1'($urandom_range(0, 1)), cols[$urandom_range(0, 4)]};
            else        a = rows[$urandom_range(0, 3)];
            we = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            drive(1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 9) >= 7),
                  1'($urandom_range(0, 1)),
                  we, a, $urandom);
        end
        RST = 1'b0;
        repeat (CL + 2) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
